// File: rtl/uart_tx_arbiter_if.sv
// Handshake and transmitter-side bundle for the UART TX arbiter.
// master: requesters plus the transmitter busy line; slave: the arbiter.
interface uart_tx_arbiter_if #(
    parameter int FRAME_WIDTH = 8
);
    logic                   req0_valid;
    logic                   req1_valid;
    logic [FRAME_WIDTH-1:0] req0_data;
    logic [FRAME_WIDTH-1:0] req1_data;
    logic                   req0_par_en;
    logic                   req0_par_typ;
    logic                   req1_par_en;
    logic                   req1_par_typ;
    logic                   req0_ready;
    logic                   req1_ready;
    logic                   busy;
    logic                   Data_Valid;
    logic [FRAME_WIDTH-1:0] P_Data;
    logic                   par_en;
    logic                   PAR_TYP;
    logic                   grant_id;
    logic                   timeout_err;

    modport master (
        output req0_valid, req1_valid, req0_data, req1_data,
               req0_par_en, req0_par_typ, req1_par_en, req1_par_typ, busy,
        input  req0_ready, req1_ready, Data_Valid, P_Data, par_en, PAR_TYP,
               grant_id, timeout_err
    );

    modport slave (
        input  req0_valid, req1_valid, req0_data, req1_data,
               req0_par_en, req0_par_typ, req1_par_en, req1_par_typ, busy,
        output req0_ready, req1_ready, Data_Valid, P_Data, par_en, PAR_TYP,
               grant_id, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between two requesters.
// Launches one frame at a time and waits for the transmitter to go busy and
// finish; flags a timeout when busy never rises after a launch.
module uart_tx_arbiter #(
    parameter int FRAME_WIDTH = 8,
    parameter int TIMEOUT     = 16
) (
    input logic              clk,
    input logic              reset,
    uart_tx_arbiter_if.slave bus
);
    localparam int              CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   last_grant_q, last_grant_d;
    logic                   dv_q, dv_d;
    logic                   to_q, to_d;
    logic [FRAME_WIDTH-1:0] p_data_q, p_data_d;
    logic                   par_en_q, par_en_d;
    logic                   par_typ_q, par_typ_d;
    logic                   grant_q, grant_d;
    logic                   win0, win1;

    assign bus.Data_Valid  = dv_q;
    assign bus.P_Data      = p_data_q;
    assign bus.par_en      = par_en_q;
    assign bus.PAR_TYP     = par_typ_q;
    assign bus.grant_id    = grant_q;
    assign bus.timeout_err = to_q;

    // Next-state, arbitration and combinational ready generation
    always_comb begin
        win0         = bus.req0_valid && (!bus.req1_valid || last_grant_q);
        win1         = bus.req1_valid && (!bus.req0_valid || !last_grant_q);
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        p_data_d     = p_data_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        grant_d      = grant_q;
        dv_d         = 1'b0;
        to_d         = 1'b0;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;

        case (state_q)
            IDLE: begin
                if (reset && !bus.busy && (win0 || win1)) begin
                    bus.req0_ready = win0;
                    bus.req1_ready = win1;
                    p_data_d       = win1 ? bus.req1_data    : bus.req0_data;
                    par_en_d       = win1 ? bus.req1_par_en  : bus.req0_par_en;
                    par_typ_d      = win1 ? bus.req1_par_typ : bus.req0_par_typ;
                    grant_d        = win1;
                    last_grant_d   = win1;
                    dv_d           = 1'b1;
                    state_d        = LAUNCH;
                end
            end
            LAUNCH: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.busy) begin
                    cnt_d   = '0;
                    state_d = WAIT_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    // counter reaches TIMEOUT on this edge; error is registered
                    // so it shows in the first IDLE cycle
                    cnt_d   = '0;
                    to_d    = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_DONE: begin
                if (!bus.busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            dv_q         <= 1'b0;
            to_q         <= 1'b0;
            p_data_q     <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            grant_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            dv_q         <= dv_d;
            to_q         <= to_d;
            p_data_q     <= p_data_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            grant_q      <= grant_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: scoreboard of accepted frames
// checked against launches, plus directed single/contention/busy/timeout/reset cases.
module tb_uart_tx_arbiter;
    localparam int FW = 8;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.FRAME_WIDTH(FW)) bus ();

    uart_tx_arbiter #(
        .FRAME_WIDTH(FW),
        .TIMEOUT    (TO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct packed {
        logic          gid;
        logic [FW-1:0] data;
        logic          pe;
        logic          pt;
    } exp_t;

    exp_t sb[$];
    exp_t last_e;
    bit   have_last;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int bm    = -1;
    bit use_model;
    logic tb_last;
    int acc_cyc = -10;
    logic dv_prev;

    logic s_rdy0, s_rdy1, s_dv, s_to, s_pe, s_pt, s_gid;
    logic [FW-1:0] s_pd;
    int s_cyc;

    // Compare one observed value with its expectation and count it
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Sample one cycle at negedge, run scoreboard, advance to next cycle start
    task automatic step();
        exp_t e;
        logic ew;
        @(negedge clk);
        s_rdy0 = bus.req0_ready;
        s_rdy1 = bus.req1_ready;
        s_dv   = bus.Data_Valid;
        s_to   = bus.timeout_err;
        s_pd   = bus.P_Data;
        s_pe   = bus.par_en;
        s_pt   = bus.PAR_TYP;
        s_gid  = bus.grant_id;
        s_cyc  = cyc;
        if (reset) begin
            check_eq("both_rdy", s_rdy0 & s_rdy1, 0);
            if ((s_rdy0 && bus.req0_valid) || (s_rdy1 && bus.req1_valid)) begin
                ew = (bus.req0_valid && bus.req1_valid) ? !tb_last : bus.req1_valid;
                check_eq("rr_win", s_rdy1, ew);
                e.gid  = ew;
                e.data = ew ? bus.req1_data    : bus.req0_data;
                e.pe   = ew ? bus.req1_par_en  : bus.req0_par_en;
                e.pt   = ew ? bus.req1_par_typ : bus.req0_par_typ;
                sb.push_back(e);
                tb_last = ew;
                acc_cyc = cyc;
            end
            if (dv_prev) check_eq("dv_width", s_dv, 0);
            if (s_dv) begin
                check_eq("dv_lat", cyc, acc_cyc + 1);
                check_eq("sb_pop", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check_eq("p_data", s_pd, e.data);
                    check_eq("par_en", s_pe, e.pe);
                    check_eq("par_typ", s_pt, e.pt);
                    check_eq("grant_id", s_gid, e.gid);
                    last_e    = e;
                    have_last = 1'b1;
                end
                bm = 0;
            end else if (have_last) begin
                check_eq("hold_data", s_pd, last_e.data);
                check_eq("hold_gid", s_gid, last_e.gid);
                check_eq("hold_par", {s_pe, s_pt}, {last_e.pe, last_e.pt});
            end
            dv_prev = s_dv;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (bm >= 0) bm++;
        if (bm >= 12) bm = -1;
        if (use_model) bus.busy = (bm >= 2);
    endtask

    task automatic drain(input int n);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        repeat (n) step();
    endtask

    // Hold reset low two cycles with both requesters valid, check reset values
    task automatic apply_reset();
        reset = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        step();
        step();
        check_eq("rst_rdy", {s_rdy0, s_rdy1}, 0);
        check_eq("rst_dv", s_dv, 0);
        check_eq("rst_pdata", s_pd, 0);
        check_eq("rst_par", {s_pe, s_pt}, 0);
        check_eq("rst_gid", s_gid, 0);
        check_eq("rst_to", s_to, 0);
        sb.delete();
        have_last = 1'b0;
        tb_last   = 1'b1;
        dv_prev   = 1'b0;
        bm        = -1;
        bus.busy  = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int grants[4];
        int ng;
        int t_acc;
        int found;

        reset = 1'b0;
        use_model = 1'b1;
        tb_last = 1'b1;
        dv_prev = 1'b0;
        have_last = 1'b0;
        bus.busy = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_data = '0;
        bus.req1_data = '0;
        bus.req0_par_en = 1'b0;
        bus.req0_par_typ = 1'b0;
        bus.req1_par_en = 1'b0;
        bus.req1_par_typ = 1'b0;
        @(posedge clk);
        #1;

        // single requester
        apply_reset();
        bus.req0_valid = 1'b1;
        bus.req0_data = 8'hA5;
        bus.req0_par_en = 1'b1;
        bus.req0_par_typ = 1'b0;
        step();
        check_eq("single_rdy", {s_rdy0, s_rdy1}, 2'b10);
        bus.req0_valid = 1'b0;
        step();
        check_eq("single_dv", s_dv, 1);
        check_eq("single_pd", s_pd, 8'hA5);
        step();
        check_eq("single_dv_end", s_dv, 0);
        drain(16);

        // contention from reset
        apply_reset();
        bus.req0_data = 8'h11;
        bus.req1_data = 8'h22;
        bus.req0_par_en = 1'b1;
        bus.req0_par_typ = 1'b1;
        bus.req1_par_en = 1'b0;
        bus.req1_par_typ = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        ng = 0;
        for (int i = 0; i < 120 && ng < 4; i++) begin
            step();
            if (s_rdy0 || s_rdy1) begin
                grants[ng] = s_rdy1 ? 1 : 0;
                ng++;
            end
        end
        check_eq("cont_count", ng, 4);
        for (int k = 0; k < ng; k++) check_eq("cont_order", grants[k], k % 2);
        drain(20);

        // busy held in IDLE blocks acceptance
        use_model = 1'b0;
        bus.busy = 1'b1;
        bus.req1_data = 8'h3C;
        bus.req1_valid = 1'b1;
        repeat (4) begin
            step();
            check_eq("bh_rdy1", s_rdy1, 0);
        end
        bus.busy = 1'b0;
        step();
        check_eq("bh_accept", s_rdy1, 1);
        bus.req1_valid = 1'b0;
        use_model = 1'b1;
        drain(20);

        // timeout: busy never rises
        use_model = 1'b0;
        bus.busy = 1'b0;
        bus.req0_data = 8'h5A;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b0;
        step();
        check_eq("to_acc", s_rdy0, 1);
        t_acc = s_cyc;
        bus.req0_valid = 1'b0;
        found = -1;
        for (int i = 0; i < 3 * TO + 8 && found < 0; i++) begin
            step();
            if (s_to) found = s_cyc;
        end
        check_eq("to_cycle", found, t_acc + 2 + TO);
        step();
        check_eq("to_width", s_to, 0);
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        step();
        check_eq("to_rr", {s_rdy0, s_rdy1}, 2'b01);
        use_model = 1'b1;
        drain(20);

        // reset during WAIT_DONE
        bus.req0_data = 8'h77;
        bus.req1_data = 8'h88;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            step();
            if (s_rdy0 || s_rdy1) found = 1;
        end
        check_eq("mf_acc", found, 1);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        for (int i = 0; i < 20 && bm < 5; i++) step();
        check_eq("mf_busy", bus.busy, 1);
        apply_reset();
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        step();
        check_eq("mf_first", {s_rdy0, s_rdy1}, 2'b10);
        drain(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
